// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, latches instruction words
// from 1-cycle block RAM and sequences FETCH/LATCH/EXEC/MEM.
module fetch_sequencer #(
  parameter int              ADDR_W   = 10,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [15:0]       mem_rdata,
  input  logic [1:0]        instr_type,
  input  logic [15:0]       jump_target,
  input  logic              flag_z,
  input  logic              flag_n,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  output logic [15:0]       instr_out,
  output logic              instr_valid,
  output logic              mem_phase,
  output logic [ADDR_W-1:0] pc_out
);

  localparam logic [3:0] S_FETCH = 4'b0001;
  localparam logic [3:0] S_LATCH = 4'b0010;
  localparam logic [3:0] S_EXEC  = 4'b0100;
  localparam logic [3:0] S_MEM   = 4'b1000;

  localparam logic [1:0] T_STORE = 2'b01;
  localparam logic [1:0] T_LOAD  = 2'b10;
  localparam logic [1:0] T_JMP   = 2'b11;

  localparam logic [3:0] OP_JUMP   = 4'b0100;
  localparam logic [3:0] OP_BRANCH = 4'b1100;

  logic [3:0]        state_q;
  logic [3:0]        state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] pc_seq;
  logic [ADDR_W-1:0] pc_rel;
  logic [15:0]       ir_q;
  logic              is_fetch;
  logic              is_latch;
  logic              is_exec;
  logic              is_mem;
  logic              is_ldst;
  logic              taken;
  logic              pc_upd;
  logic              unused_jt;

  assign unused_jt = ^jump_target[15:ADDR_W];

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  assign is_ldst = (instr_type == T_LOAD) ||
                   (instr_type == T_STORE);

  // Next-state logic; any non-one-hot value falls back to FETCH
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = run ? S_LATCH : S_FETCH;
      S_LATCH: state_d = S_EXEC;
      S_EXEC:  state_d = is_ldst ? S_MEM : S_FETCH;
      S_MEM:   state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  // Output decode; reset masks strobes so an aborted EXEC never pulses
  always_comb begin
    is_fetch = 1'b0;
    is_latch = 1'b0;
    is_exec  = 1'b0;
    is_mem   = 1'b0;
    case (state_q)
      S_FETCH: is_fetch = 1'b1;
      S_LATCH: is_latch = 1'b1;
      S_EXEC:  is_exec  = 1'b1;
      S_MEM:   is_mem   = 1'b1;
      default: is_fetch = 1'b0;
    endcase
  end

  assign mem_en      = is_fetch & run & ~reset;
  assign instr_valid = is_exec & ~reset;
  assign mem_phase   = is_mem & ~reset;

  // Branch condition from the latched instruction
  always_comb begin
    taken = 1'b0;
    case (ir_q[7:4])
      4'b0000: taken = flag_z;
      4'b0001: taken = ~flag_z;
      4'b0110: taken = ~flag_z & ~flag_n;
      4'b0111: taken = flag_z | flag_n;
      4'b1110: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  assign pc_seq = pc_q + ADDR_W'(1);
  assign pc_rel = pc_q +
    {{(ADDR_W-8){ir_q[7]}}, ir_q[7:0]};

  always_comb begin
    pc_d = pc_seq;
    if (is_exec && instr_type == T_JMP && taken) begin
      if (ir_q[15:12] == OP_JUMP)
        pc_d = jump_target[ADDR_W-1:0];
      else if (ir_q[15:12] == OP_BRANCH)
        pc_d = pc_rel;
    end
  end

  assign pc_upd = (is_exec & ~is_ldst) | is_mem;

  always_ff @(posedge clk) begin
    if (reset)       pc_q <= RESET_PC;
    else if (pc_upd) pc_q <= pc_d;
  end

  always_ff @(posedge clk) begin
    if (reset)         ir_q <= 16'h0000;
    else if (is_latch) ir_q <= mem_rdata;
  end

  assign mem_addr  = pc_q;
  assign pc_out    = pc_q;
  assign instr_out = ir_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: small program in a model RAM,
// checks fetch addresses, strobes and branch/jump targets.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [15:0] mem_rdata;
  logic [1:0]  instr_type;
  logic [15:0] jump_target;
  logic        flag_z;
  logic        flag_n;
  logic [9:0]  mem_addr;
  logic        mem_en;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic        mem_phase;
  logic [9:0]  pc_out;

  logic [15:0] ram [0:1023];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(.ADDR_W(10), .RESET_PC(10'd0)) dut (
    .clk(clk), .reset(reset), .run(run),
    .mem_rdata(mem_rdata), .instr_type(instr_type),
    .jump_target(jump_target), .flag_z(flag_z),
    .flag_n(flag_n), .mem_addr(mem_addr),
    .mem_en(mem_en), .instr_out(instr_out),
    .instr_valid(instr_valid), .mem_phase(mem_phase),
    .pc_out(pc_out)
  );

  always_ff @(posedge clk)
    if (mem_en) mem_rdata <= ram[mem_addr];

  // Decoder model: type from opcode nibble
  always_comb begin
    instr_type = 2'b00;
    case (instr_out[15:12])
      4'h4, 4'hC: instr_type = 2'b11;
      4'h9:       instr_type = 2'b10;
      4'hD:       instr_type = 2'b01;
      default:    instr_type = 2'b00;
    endcase
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 16'h0000;
    ram[0]    = 16'h0512;
    ram[1]    = 16'h0534;
    ram[2]    = 16'h4EE5;
    ram[5]    = 16'h9000;
    ram[6]    = 16'hD000;
    ram[7]    = 16'h4EE5;
    ram[10]   = 16'hC11D;
    ram[11]   = 16'h4EE5;
    ram[39]   = 16'h4EE5;
    ram[291]  = 16'h4665;
    ram[292]  = 16'h4EE5;
    ram[1023] = 16'hC002;
    mem_rdata   = 16'h0000;
    reset       = 1'b1;
    run         = 1'b1;
    jump_target = 16'h0000;
    flag_z      = 1'b0;
    flag_n      = 1'b0;

    cyc(2);
    chk("rst_pc", 16'(pc_out), 16'h0000);
    chk("rst_ir", instr_out, 16'h0000);
    chk("rst_valid", 16'(instr_valid), 16'h0);
    chk("rst_memen", 16'(mem_en), 16'h0);
    chk("rst_mphase", 16'(mem_phase), 16'h0);

    reset = 1'b0;
    #1;
    chk("f0_memen", 16'(mem_en), 16'h1);
    chk("f0_addr", 16'(mem_addr), 16'h0000);
    cyc(1);
    chk("l0_valid", 16'(instr_valid), 16'h0);
    cyc(1);
    chk("e0_valid", 16'(instr_valid), 16'h1);
    chk("e0_ir", instr_out, 16'h0512);
    cyc(1);
    chk("f1_valid", 16'(instr_valid), 16'h0);
    chk("f1_addr", 16'(mem_addr), 16'h0001);
    cyc(2);
    chk("e1_valid", 16'(instr_valid), 16'h1);
    chk("e1_ir", instr_out, 16'h0534);
    cyc(1);
    chk("f2_addr", 16'(mem_addr), 16'h0002);

    // Jump: upper target bits discarded
    jump_target = 16'hF123;
    cyc(3);
    chk("jmp_trunc", 16'(mem_addr), 16'h0123);
    flag_n = 1'b1;
    cyc(3);
    chk("jgt_not", 16'(pc_out), 16'h0124);
    flag_n = 1'b0;
    jump_target = 16'h0005;
    cyc(3);
    chk("jmp_5", 16'(mem_addr), 16'h0005);

    // Load: EXEC then MEM, next fetch at 6
    cyc(2);
    chk("ld_valid", 16'(instr_valid), 16'h1);
    chk("ld_mp0", 16'(mem_phase), 16'h0);
    cyc(1);
    chk("ld_mp1", 16'(mem_phase), 16'h1);
    chk("ld_valid0", 16'(instr_valid), 16'h0);
    chk("ld_pc_hold", 16'(pc_out), 16'h0005);
    cyc(1);
    chk("ld_next", 16'(mem_addr), 16'h0006);
    chk("ld_mp_off", 16'(mem_phase), 16'h0);
    cyc(3);
    chk("st_mp1", 16'(mem_phase), 16'h1);
    cyc(1);
    chk("st_next", 16'(mem_addr), 16'h0007);

    jump_target = 16'h000A;
    cyc(3);
    chk("jmp_a", 16'(mem_addr), 16'h000A);
    // BNE +0x1D from 10
    flag_z = 1'b0;
    cyc(3);
    chk("bne_taken", 16'(mem_addr), 16'h0027);
    cyc(3);
    chk("jmp_a2", 16'(mem_addr), 16'h000A);
    flag_z = 1'b1;
    cyc(3);
    chk("bne_not", 16'(mem_addr), 16'h000B);
    jump_target = 16'h03FF;
    cyc(3);
    chk("jmp_3ff", 16'(mem_addr), 16'h03FF);
    // BEQ +2 from 1023 wraps to 1
    cyc(3);
    chk("beq_wrap", 16'(mem_addr), 16'h0001);

    // Reset during EXEC aborts the instruction
    flag_z = 1'b0;
    cyc(2);
    reset = 1'b1;
    #1;
    chk("abort_valid", 16'(instr_valid), 16'h0);
    cyc(1);
    chk("abort_pc", 16'(pc_out), 16'h0000);
    chk("abort_ir", instr_out, 16'h0000);
    ram[0]    = 16'hCEEF;
    ram[1007] = 16'h0512;
    reset = 1'b0;
    // Unconditional branch -17 from 0 wraps to 1007
    cyc(3);
    chk("bwrap_neg", 16'(mem_addr), 16'h03EF);

    // run dropped in LATCH: instruction completes then holds
    cyc(1);
    run = 1'b0;
    cyc(1);
    chk("run0_valid", 16'(instr_valid), 16'h1);
    chk("run0_ir", instr_out, 16'h0512);
    cyc(1);
    chk("run0_addr", 16'(mem_addr), 16'h03F0);
    chk("run0_memen", 16'(mem_en), 16'h0);
    cyc(3);
    chk("hold_addr", 16'(mem_addr), 16'h03F0);
    chk("hold_valid", 16'(instr_valid), 16'h0);
    chk("hold_memen", 16'(mem_en), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
